// File: rtl/simple_proc_pkg.sv
// Shared types for the simple processor: ALU select codes, opcodes, sequencer
// states and instruction field positions.
package simple_proc_pkg;

  localparam int OPC_LSB = 12;
  localparam int RX_LSB  = 9;
  localparam int RY_LSB  = 6;
  localparam int OPC_W   = 4;
  localparam int FLD_W   = 3;

  typedef enum logic [2:0] {
    SEL_ZERO    = 3'd0,
    SEL_ADD     = 3'd1,
    SEL_ABSDIFF = 3'd2,
    SEL_PASSA   = 3'd3,
    SEL_XOR     = 3'd4,
    SEL_OR      = 3'd5,
    SEL_AND     = 3'd6,
    SEL_INC     = 3'd7
  } alu_sel_e;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_LOAD    = 4'd1,
    OP_MOV     = 4'd2,
    OP_ADD     = 4'd3,
    OP_ABSDIFF = 4'd4,
    OP_XOR     = 4'd5,
    OP_OR      = 4'd6,
    OP_AND     = 4'd7,
    OP_INC     = 4'd8,
    OP_CLR     = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    DONE   = 3'd3,
    HALT   = 3'd4
  } seq_state_e;

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return opc <= 4'(OP_CLR);
  endfunction

endpackage

// File: rtl/reg_file.sv
// NREGS x DATA_W register file: two combinational read ports, one synchronous
// write port, whole array cleared synchronously by Reset.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [AW-1:0]     rd_a_idx,
  input  logic [AW-1:0]     rd_b_idx,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;

  assign rd_a_data = regs_q[rd_a_idx];
  assign rd_b_data = regs_q[rd_b_idx];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_idx] = wr_data;
  end

  // Reset wins over a same-cycle write so a dropped instruction leaves no trace.
  always_ff @(posedge Clock) begin
    if (Reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer driving an external combinational ALU: IDLE -> DECODE -> EXEC -> DONE.
// Optional macro ILLEGAL_TRAP_EN traps illegal opcodes into a sticky HALT with err.
module alu_sequencer
  import simple_proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] data_in,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [2:0]        alu_s,
  input  logic [DATA_W-1:0] alu_Q,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int AW = $clog2(NREGS);

  // Handshake: an instruction transfers on a rising edge where
  // instr_valid && instr_ready && !Reset; instr_ready is high only in IDLE.

  seq_state_e         state_q, state_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [FLD_W-1:0]   rx_q, rx_d;
  logic [FLD_W-1:0]   ry_q, ry_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  alu_a_q, alu_a_d;
  logic [DATA_W-1:0]  alu_b_q, alu_b_d;
  logic [2:0]         alu_s_q, alu_s_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               err_q, err_d;

  logic [DATA_W-1:0]  rd_a_data, rd_b_data;
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic               writes_rx;
  logic               unused_bits;

  assign unused_bits = ^{instr[5:0], rx_q, ry_q};
  assign writes_rx   = (opc_q >= 4'(OP_LOAD)) && (opc_q <= 4'(OP_CLR));

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS)) u_reg_file (
    .Clock     (Clock),
    .Reset     (Reset),
    .rd_a_idx  (rx_q[AW-1:0]),
    .rd_b_idx  (ry_q[AW-1:0]),
    .rd_a_data (rd_a_data),
    .rd_b_data (rd_b_data),
    .wr_en     (wr_en),
    .wr_idx    (rx_q[AW-1:0]),
    .wr_data   (wr_data)
  );

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    rx_d     = rx_q;
    ry_d     = ry_q;
    data_d   = data_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_s_d  = alu_s_q;
    done_d   = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    wr_data  = (opc_q == 4'(OP_LOAD)) ? data_q : alu_Q;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          opc_d   = instr[OPC_LSB +: OPC_W];
          rx_d    = instr[RX_LSB +: FLD_W];
          ry_d    = instr[RY_LSB +: FLD_W];
          data_d  = data_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_a_d = '0;
        alu_b_d = '0;
        alu_s_d = SEL_ZERO;
        case (opc_q)
          OP_MOV:     begin alu_a_d = rd_b_data; alu_s_d = SEL_PASSA; end
          OP_ADD:     begin alu_a_d = rd_a_data; alu_b_d = rd_b_data; alu_s_d = SEL_ADD; end
          OP_ABSDIFF: begin alu_a_d = rd_a_data; alu_b_d = rd_b_data; alu_s_d = SEL_ABSDIFF; end
          OP_XOR:     begin alu_a_d = rd_a_data; alu_b_d = rd_b_data; alu_s_d = SEL_XOR; end
          OP_OR:      begin alu_a_d = rd_a_data; alu_b_d = rd_b_data; alu_s_d = SEL_OR; end
          OP_AND:     begin alu_a_d = rd_a_data; alu_b_d = rd_b_data; alu_s_d = SEL_AND; end
          OP_INC:     begin alu_a_d = rd_a_data; alu_s_d = SEL_INC; end
          default:    ;
        endcase
        state_d = EXEC;
      end
      EXEC: begin
        wr_en    = writes_rx;
        result_d = writes_rx ? wr_data : '0;
        done_d   = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        if (!is_legal(opc_q)) err_d = 1'b1;
`endif
        state_d  = DONE;
      end
      DONE: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = err_q ? HALT : IDLE;
`else
        state_d = IDLE;
`endif
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      opc_q    <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      data_q   <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_s_q  <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opc_q    <= opc_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      data_q   <= data_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_s_q  <= alu_s_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_s       = alu_s_q;
  assign done        = done_q;
  assign result      = result_q;
  assign err         = err_q;
  assign dbg_state   = state_q;

endmodule
